// File: rtl/mc_control_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_control_fsm : multi-cycle MIPS control unit (stall, memory handshake with timeout, halt)
// Revision: 1.0
// ----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int         MEM_TIMEOUT = 15,
  parameter bit         EXT_ISA     = 1'b1,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       stall,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [2:0] aluop,
  output logic       alusrc,
  output logic       branch,
  output logic       branch_ne,
  output logic       jump,
  output logic       memread,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcupdate,
  output logic       halted,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PCUPD  = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_jal  = 6'b000011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_bne  = 6'b000101;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_slti = 6'b001010;
  localparam logic [5:0] c_op_andi = 6'b001100;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;

  localparam int                c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(MEM_TIMEOUT);

  state_t             r_state;
  logic [5:0]         r_opcode;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_regdst, r_memtoreg;
  logic [2:0]         r_aluop;
  logic               r_alusrc, r_branch, r_branch_ne, r_jump;
  logic               r_illegal, r_timeout;

  logic [1:0] w_regdst, w_memtoreg;
  logic [2:0] w_aluop;
  logic       w_alusrc, w_branch, w_branch_ne, w_jump, w_legal;

  always_comb begin
    w_legal     = 1'b0;
    w_regdst    = 2'b00;
    w_memtoreg  = 2'b00;
    w_aluop     = 3'b111;
    w_alusrc    = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    w_jump      = 1'b0;
    case (opcode)
      c_op_r:    begin w_legal = 1'b1; w_regdst = 2'b01; w_aluop = 3'b010; end
      c_op_addi: begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b000; end
      c_op_lw:   begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b000; w_memtoreg = 2'b01; end
      c_op_sw:   begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b000; end
      c_op_beq:  begin w_legal = 1'b1; w_branch = 1'b1; w_aluop = 3'b001; end
      c_op_j:    begin w_legal = 1'b1; w_jump = 1'b1; end
      c_op_bne:  if (EXT_ISA) begin w_legal = 1'b1; w_branch_ne = 1'b1; w_aluop = 3'b001; end
      c_op_jal:  if (EXT_ISA) begin w_legal = 1'b1; w_jump = 1'b1; w_regdst = 2'b10; w_memtoreg = 2'b10; end
      c_op_andi: if (EXT_ISA) begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b011; end
      c_op_ori:  if (EXT_ISA) begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b100; end
      c_op_slti: if (EXT_ISA) begin w_legal = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b101; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_opcode    <= '0;
      r_cnt       <= '0;
      r_regdst    <= 2'b00;
      r_memtoreg  <= 2'b00;
      r_aluop     <= 3'b111;
      r_alusrc    <= 1'b0;
      r_branch    <= 1'b0;
      r_branch_ne <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (!stall) r_state <= S_DECODE;
        S_DECODE: if (!stall) begin
          r_opcode <= opcode;
          if (opcode == HALT_OPCODE) begin
            r_state <= S_HALT;
          end else if (!w_legal) begin
            r_state   <= S_ERR;
            r_illegal <= 1'b1;
          end else begin
            r_state     <= S_EXEC;
            r_regdst    <= w_regdst;
            r_memtoreg  <= w_memtoreg;
            r_aluop     <= w_aluop;
            r_alusrc    <= w_alusrc;
            r_branch    <= w_branch;
            r_branch_ne <= w_branch_ne;
            r_jump      <= w_jump;
          end
        end
        S_EXEC: if (!stall) begin
          case (r_opcode)
            c_op_lw, c_op_sw: begin
              r_state <= S_MEM;
              r_cnt   <= c_cnt_w'(1);
            end
            c_op_beq, c_op_bne, c_op_j: r_state <= S_PCUPD;
            default:                    r_state <= S_WB;
          endcase
        end
        // A ready on the final allowed cycle still wins over the timeout.
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (r_opcode == c_op_lw) ? S_WB : S_PCUPD;
            r_cnt   <= '0;
          end else if (MEM_TIMEOUT != 0 && r_cnt == c_limit) begin
            r_state     <= S_ERR;
            r_timeout   <= 1'b1;
            r_cnt       <= '0;
            r_regdst    <= 2'b00;
            r_memtoreg  <= 2'b00;
            r_aluop     <= 3'b111;
            r_alusrc    <= 1'b0;
            r_branch    <= 1'b0;
            r_branch_ne <= 1'b0;
            r_jump      <= 1'b0;
          end else if (MEM_TIMEOUT != 0) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_WB: if (!stall) r_state <= S_PCUPD;
        S_PCUPD: if (!stall) begin
          r_state     <= S_FETCH;
          r_regdst    <= 2'b00;
          r_memtoreg  <= 2'b00;
          r_aluop     <= 3'b111;
          r_alusrc    <= 1'b0;
          r_branch    <= 1'b0;
          r_branch_ne <= 1'b0;
          r_jump      <= 1'b0;
        end
        S_HALT: r_state <= S_HALT;
        S_ERR:  r_state <= S_ERR;
      endcase
    end
  end

  assign irwrite     = (r_state == S_FETCH) && !stall;
  assign regwrite    = (r_state == S_WB) && !stall;
  assign pcupdate    = (r_state == S_PCUPD) && !stall;
  assign memread     = (r_state == S_MEM) && (r_opcode == c_op_lw);
  assign memwrite    = (r_state == S_MEM) && (r_opcode == c_op_sw);
  assign halted      = (r_state == S_HALT);
  assign illegal     = r_illegal;
  assign mem_timeout = r_timeout;
  assign state       = r_state;
  assign regdst      = r_regdst;
  assign memtoreg    = r_memtoreg;
  assign aluop       = r_aluop;
  assign alusrc      = r_alusrc;
  assign branch      = r_branch;
  assign branch_ne   = r_branch_ne;
  assign jump        = r_jump;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mc_control_fsm : table-driven check of mc_control_fsm plus multi-cycle corner sequences
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n, stall, mem_ready;
  logic [5:0] opcode;

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: EXT_ISA=0; 2: HALT_OPCODE=3E
  logic       irwrite [3], alusrc [3], branch [3], branch_ne [3], jump [3];
  logic       memread [3], memwrite [3], regwrite [3], pcupdate [3];
  logic       halted [3], illegal [3], mem_timeout [3];
  logic [1:0] regdst [3], memtoreg [3];
  logic [2:0] aluop [3], state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_control_fsm #(
      .MEM_TIMEOUT(15),
      .EXT_ISA    (g != 1),
      .HALT_OPCODE(g == 2 ? 6'h3E : 6'h3F)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .stall      (stall),
      .mem_ready  (mem_ready),
      .irwrite    (irwrite[g]),
      .regdst     (regdst[g]),
      .memtoreg   (memtoreg[g]),
      .aluop      (aluop[g]),
      .alusrc     (alusrc[g]),
      .branch     (branch[g]),
      .branch_ne  (branch_ne[g]),
      .jump       (jump[g]),
      .memread    (memread[g]),
      .memwrite   (memwrite[g]),
      .regwrite   (regwrite[g]),
      .pcupdate   (pcupdate[g]),
      .halted     (halted[g]),
      .illegal    (illegal[g]),
      .mem_timeout(mem_timeout[g]),
      .state      (state[g])
    );
  end

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;

  // {regdst, memtoreg, aluop, alusrc, branch, branch_ne, jump}
  localparam logic [10:0] C_IDLE = 11'b00_00_111_0000;
  localparam logic [10:0] C_R    = 11'b01_00_010_0000;
  localparam logic [10:0] C_ADDI = 11'b00_00_000_1000;
  localparam logic [10:0] C_LW   = 11'b00_01_000_1000;
  localparam logic [10:0] C_SW   = 11'b00_00_000_1000;
  localparam logic [10:0] C_BEQ  = 11'b00_00_001_0100;
  localparam logic [10:0] C_BNE  = 11'b00_00_001_0010;
  localparam logic [10:0] C_J    = 11'b00_00_111_0001;
  localparam logic [10:0] C_JAL  = 11'b10_10_111_0001;
  localparam logic [10:0] C_ANDI = 11'b00_00_011_1000;
  localparam logic [10:0] C_ORI  = 11'b00_00_100_1000;
  localparam logic [10:0] C_SLTI = 11'b00_00_101_1000;

  // sb = {irwrite, memread, memwrite, regwrite, pcupdate}
  typedef struct {
    logic        r, s, m;
    logic [5:0]  op;
    logic [2:0]  st;
    logic [4:0]  sb;
    logic [10:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, s, m, input logic [5:0] op, input logic [2:0] st,
                     input logic [4:0] sb, input logic [10:0] ctl);
    vec_t v;
    v.r = r; v.s = s; v.m = m; v.op = op; v.st = st; v.sb = sb; v.ctl = ctl;
    tbl.push_back(v);
  endtask

  // No-stall instruction through WB (5 cycles) or straight to PCUPD (4 cycles)
  task automatic add_wb(input logic [5:0] op, input logic [10:0] ctl);
    add(1, 0, 0, op, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, op, 3'd1, 5'b00000, C_IDLE);
    add(1, 0, 0, op, 3'd2, 5'b00000, ctl);
    add(1, 0, 0, op, 3'd4, 5'b00010, ctl);
    add(1, 0, 0, op, 3'd5, 5'b00001, ctl);
  endtask

  task automatic add_br(input logic [5:0] op, input logic [10:0] ctl);
    add(1, 0, 0, op, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, op, 3'd1, 5'b00000, C_IDLE);
    add(1, 0, 0, op, 3'd2, 5'b00000, ctl);
    add(1, 0, 0, op, 3'd5, 5'b00001, ctl);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] sb_of(input int i);
    return {irwrite[i], memread[i], memwrite[i], regwrite[i], pcupdate[i]};
  endfunction

  function automatic logic [10:0] ctl_of(input int i);
    return {regdst[i], memtoreg[i], aluop[i], alusrc[i], branch[i], branch_ne[i], jump[i]};
  endfunction

  function automatic logic [2:0] flg_of(input int i);
    return {halted[i], illegal[i], mem_timeout[i]};
  endfunction

  task automatic chkd(input string nm, input int i, input logic [2:0] st,
                      input logic [4:0] sb, input logic [2:0] fl);
    chk({nm, " state"},   16'(state[i]),  16'(st));
    chk({nm, " strobes"}, 16'(sb_of(i)),  16'(sb));
    chk({nm, " flags"},   16'(flg_of(i)), 16'(fl));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later
  task automatic cyc(input logic r, s, m, input logic [5:0] op);
    @(negedge clk);
    rst_n = r; stall = s; mem_ready = m; opcode = op;
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 1, 0, OP_R);
    cyc(0, 1, 0, OP_R);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    repeat (2) @(posedge clk);

    add(0, 1, 0, OP_R, 3'd0, 5'b00000, C_IDLE);
    add(1, 0, 0, OP_R, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, OP_R, 3'd1, 5'b00000, C_IDLE);
    add(1, 0, 0, OP_R, 3'd2, 5'b00000, C_R);
    add(1, 0, 0, OP_R, 3'd4, 5'b00010, C_R);
    add(1, 0, 0, OP_R, 3'd5, 5'b00001, C_R);
    // LW: ready low for three MEM cycles, nine cycles total
    add(1, 0, 0, OP_LW, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, OP_LW, 3'd1, 5'b00000, C_IDLE);
    add(1, 0, 0, OP_LW, 3'd2, 5'b00000, C_LW);
    add(1, 0, 0, OP_LW, 3'd3, 5'b01000, C_LW);
    add(1, 0, 0, OP_LW, 3'd3, 5'b01000, C_LW);
    add(1, 0, 0, OP_LW, 3'd3, 5'b01000, C_LW);
    add(1, 0, 1, OP_LW, 3'd3, 5'b01000, C_LW);
    add(1, 0, 0, OP_LW, 3'd4, 5'b00010, C_LW);
    add(1, 0, 0, OP_LW, 3'd5, 5'b00001, C_LW);
    // ADDI with stalls in FETCH, EXEC and two cycles of WB
    add(1, 1, 0, OP_ADDI, 3'd0, 5'b00000, C_IDLE);
    add(1, 0, 0, OP_ADDI, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, OP_ADDI, 3'd1, 5'b00000, C_IDLE);
    add(1, 1, 0, OP_ADDI, 3'd2, 5'b00000, C_ADDI);
    add(1, 0, 0, OP_ADDI, 3'd2, 5'b00000, C_ADDI);
    add(1, 1, 0, OP_ADDI, 3'd4, 5'b00000, C_ADDI);
    add(1, 1, 0, OP_ADDI, 3'd4, 5'b00000, C_ADDI);
    add(1, 0, 0, OP_ADDI, 3'd4, 5'b00010, C_ADDI);
    add(1, 0, 0, OP_ADDI, 3'd5, 5'b00001, C_ADDI);
    // SW: stall is ignored in MEM
    add(1, 0, 0, OP_SW, 3'd0, 5'b10000, C_IDLE);
    add(1, 0, 0, OP_SW, 3'd1, 5'b00000, C_IDLE);
    add(1, 0, 0, OP_SW, 3'd2, 5'b00000, C_SW);
    add(1, 1, 1, OP_SW, 3'd3, 5'b00100, C_SW);
    add(1, 0, 0, OP_SW, 3'd5, 5'b00001, C_SW);
    add_wb(OP_JAL,  C_JAL);
    add_wb(OP_ANDI, C_ANDI);
    add_wb(OP_ORI,  C_ORI);
    add_wb(OP_SLTI, C_SLTI);
    add_br(OP_BEQ,  C_BEQ);
    add_br(OP_BNE,  C_BNE);
    add_br(OP_J,    C_J);
    add(1, 1, 0, OP_R, 3'd0, 5'b00000, C_IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].m, tbl[i].op);
      chk($sformatf("row%0d state", i),   16'(state[0]),  16'(tbl[i].st));
      chk($sformatf("row%0d strobes", i), 16'(sb_of(0)),  16'(tbl[i].sb));
      chk($sformatf("row%0d ctl", i),     16'(ctl_of(0)), 16'(tbl[i].ctl));
      chk($sformatf("row%0d flags", i),   16'(flg_of(0)), 16'(3'b000));
    end

    // SW with memory never ready: ERR after the 15th MEM cycle
    do_reset();
    cyc(1, 0, 0, OP_SW); cyc(1, 0, 0, OP_SW); cyc(1, 0, 0, OP_SW);
    for (int k = 1; k <= 15; k++) begin
      cyc(1, 1, 0, OP_SW);
      chkd($sformatf("tmo mem%0d", k), 0, 3'd3, 5'b00100, 3'b000);
    end
    cyc(1, 0, 0, OP_SW);
    chkd("tmo err", 0, 3'd7, 5'b00000, 3'b001);
    cyc(1, 0, 1, OP_SW);
    chkd("tmo sticky", 0, 3'd7, 5'b00000, 3'b001);
    cyc(0, 1, 0, OP_SW);
    chkd("tmo rst edge", 0, 3'd7, 5'b00000, 3'b001);
    cyc(1, 1, 0, OP_SW);
    chkd("tmo after rst", 0, 3'd0, 5'b00000, 3'b000);

    // Ready arriving on the 15th MEM cycle completes normally
    do_reset();
    cyc(1, 0, 0, OP_SW); cyc(1, 0, 0, OP_SW); cyc(1, 0, 0, OP_SW);
    for (int k = 1; k <= 14; k++) cyc(1, 0, 0, OP_SW);
    cyc(1, 0, 1, OP_SW);
    chkd("tmo edge mem15", 0, 3'd3, 5'b00100, 3'b000);
    cyc(1, 0, 0, OP_SW);
    chkd("tmo edge pcupd", 0, 3'd5, 5'b00001, 3'b000);

    // Reset in the middle of a load drops memread on that edge
    do_reset();
    cyc(1, 0, 0, OP_LW); cyc(1, 0, 0, OP_LW); cyc(1, 0, 0, OP_LW);
    cyc(1, 0, 0, OP_LW);
    chkd("lw mem", 0, 3'd3, 5'b01000, 3'b000);
    cyc(0, 0, 0, OP_LW);
    chkd("lw rst pending", 0, 3'd3, 5'b01000, 3'b000);
    cyc(1, 1, 0, OP_LW);
    chkd("lw rst done", 0, 3'd0, 5'b00000, 3'b000);

    // Halt opcode: HALT on default instances, ERR when HALT_OPCODE differs
    do_reset();
    cyc(1, 0, 0, 6'h3F); cyc(1, 0, 0, 6'h3F);
    cyc(1, 0, 1, 6'h3F);
    chkd("halt d0", 0, 3'd6, 5'b00000, 3'b100);
    chkd("halt d1", 1, 3'd6, 5'b00000, 3'b100);
    chkd("halt d2", 2, 3'd7, 5'b00000, 3'b010);
    cyc(1, 0, 1, OP_R);
    chkd("halt hold", 0, 3'd6, 5'b00000, 3'b100);

    // JAL is illegal without the extended ISA
    do_reset();
    cyc(1, 0, 0, OP_JAL); cyc(1, 0, 0, OP_JAL);
    cyc(1, 0, 0, OP_JAL);
    chkd("jal ext0", 1, 3'd7, 5'b00000, 3'b010);
    chkd("jal ext1", 0, 3'd2, 5'b00000, 3'b000);

    // Unknown opcode
    do_reset();
    cyc(1, 0, 0, 6'h01); cyc(1, 0, 0, 6'h01);
    cyc(1, 0, 0, 6'h01);
    chkd("illegal op", 0, 3'd7, 5'b00000, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multi-cycle MIPS control unit. It succeeds the fixed 5-count controller with an explicit state machine, synchronous reset, a stall input, a memory ready handshake with timeout, and an extended ISA (BNE, JAL, ANDI, ORI, SLTI). A halt state replaces the simulation-only finish. It sits between the instruction register and the datapath and drives all datapath enables and muxes.

Parameters:
MEM_TIMEOUT, 15, max MEM-state cycles waiting for mem_ready before error; 0 disables the timeout.
EXT_ISA, 1, 1 enables BNE/JAL/ANDI/ORI/SLTI; 0 decodes them as illegal.
HALT_OPCODE, 6'h3F, opcode that enters HALT.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  instruction opcode, sampled on the edge leaving DECODE
stall  in  1  hold current state (ignored in MEM, HALT, ERR)
mem_ready  in  1  data memory completes the access this cycle
irwrite  out  1  instruction register load strobe
regdst  out  2  00 rt, 01 rd, 10 $31
memtoreg  out  2  00 ALU, 01 memory, 10 PC+4
aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 111 idle
alusrc  out  1  1 = immediate
branch  out  1  BEQ
branch_ne  out  1  BNE
jump  out  1  J/JAL
memread  out  1  load request
memwrite  out  1  store request
regwrite  out  1  register file write strobe
pcupdate  out  1  PC write strobe
halted  out  1  in HALT
illegal  out  1  sticky, illegal opcode
mem_timeout  out  1  sticky, memory timeout
state  out  3  current state code (debug)

Behaviour:
- Reset (rst_n low at clk edge): state=FETCH; all outputs 0 except aluop=3'b111; sticky flags cleared; timeout counter 0. Reset mid-operation (including MEM) takes effect on the next edge; memread/memwrite drop at that edge.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PCUPD=5, HALT=6, ERR=7.
- FETCH: irwrite=!stall; go to DECODE if !stall.
- DECODE: if !stall, latch opcode and load decoded controls (alusrc, aluop, branch, branch_ne, jump, regdst, memtoreg). Controls stay valid EXEC through PCUPD. Next state: HALT if opcode==HALT_OPCODE; ERR with illegal=1 if the opcode is unknown; else EXEC.
- Decode table (regdst/memtoreg/alusrc/aluop):
  - R 000000: 01/00/0/010
  - ADDI 001000: 00/00/1/000
  - LW 100011: 00/01/1/000
  - SW 101011: alusrc=1, aluop 000
  - BEQ 000100: branch=1, aluop 001
  - J 000010: jump=1
  - EXT_ISA only: BNE 000101: branch_ne=1, aluop 001; JAL 000011: jump=1, regdst 10, memtoreg 10; ANDI 001100: 011; ORI 001101: 100; SLTI 001010: 101 (all immediates alusrc=1, regdst 00).
- EXEC (if !stall): LW/SW go to MEM; R/ADDI/ANDI/ORI/SLTI/JAL go to WB; BEQ/BNE/J go to PCUPD.
- MEM: memread (LW) or memwrite (SW) held high every MEM cycle. stall is ignored. When mem_ready=1: LW goes to WB, SW goes to PCUPD.
  - Timeout counter counts MEM cycles from 1. If mem_ready=0 on cycle MEM_TIMEOUT (MEM_TIMEOUT≠0), go to ERR and set mem_timeout=1.
  - mem_ready=1 on the timeout cycle completes normally.
- WB: regwrite=!stall; go to PCUPD if !stall.
- PCUPD: pcupdate=!stall. If !stall, go to FETCH; decoded controls return to idle (0, aluop 111) on that edge.
- Strobes irwrite, regwrite, pcupdate are 0 on any stalled cycle. The memory request is never deasserted mid-access except by reset.
- HALT/ERR: terminal until reset; all strobes, memread and memwrite are 0; halted=1 in HALT.
- Latency (no stall, mem_ready immediate):
  - R/ADDI/imm: 5 cycles
  - JAL: 5 cycles
  - LW: 6 cycles
  - SW: 5 cycles
  - BEQ/BNE/J: 4 cycles

Test Plan:
- Reset, then R-type 000000, stall=0 -> state 0,1,2,4,5,0. regwrite=1 only in WB with regdst=01, aluop=010. pcupdate=1 for one cycle.
- LW 100011 with mem_ready low 3 cycles then high -> memread high 4 MEM cycles, then WB with memtoreg=01, regwrite=1. Total 9 cycles.
- SW with mem_ready stuck 0, MEM_TIMEOUT=15 -> ERR after 15th MEM cycle. mem_timeout=1, memwrite=0 afterwards. rst_n=0 returns state to 0.
- JAL 000011, EXT_ISA=1 -> jump=1, regdst=10, memtoreg=10, regwrite pulse. With EXT_ISA=0 -> ERR, illegal=1.
- stall=1 for 2 cycles in WB during ADDI -> state holds 4, regwrite=0 while stalled, then a single regwrite pulse.
- Opcode 6'h3F -> HALT, halted=1, no further strobes. Opcode 6'h3F with HALT_OPCODE=6'h3E -> ERR.
